// File: rtl/jtag_dbg_bridge_pkg.sv
// Shared definitions for the JTAG debug bridge: opcodes, control/status bit
// positions, FSM state type and the command FIFO entry layout.
// Imported by the bridge top and its command FIFO.
package jtag_dbg_bridge_pkg;

  // Command opcodes carried in word[31:30] of a command (sel=0) word
  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_CTRL    = 2'b10;
  localparam logic [1:0] OP_NOP     = 2'b11;

  // CTRL command payload bits
  localparam int CTRL_RST_BIT  = 0;
  localparam int CTRL_VIEW_BIT = 1;
  localparam int CTRL_CLR_BIT  = 2;

  // Status view layout on dbgreg_out
  localparam int STAT_OVF_BIT  = 31;
  localparam int STAT_BUSY_BIT = 30;
  localparam int STAT_CNT_LSB  = 28;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  // One FIFO entry: the select bit plus the captured DR word
  typedef struct packed {
    logic        sel;
    logic [31:0] word;
  } cmd_t;

  // Word-address increment; wraps 0xFFFFFFFC -> 0x00000000 naturally
  function automatic logic [31:0] next_addr(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/jtag_dbg_bridge_cmd_fifo.sv
// Command FIFO: DEPTH entries of {sel, word}, pushed by DR strobes, popped by the bridge FSM.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: a push while full is accepted only if a pop happens in the same cycle.
module dbg_cmd_fifo
  import jtag_dbg_bridge_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  cmd_t             push_data,
  input  logic             pop,
  output cmd_t             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtag_dbg_bridge.sv
// JTAG debug bridge: turns captured DR words into SoC bus accesses and CPU reset control.
// Latency: strobe at t, decode at t+1, register effects and bus request from t+2.
// Backpressure: bus stalls fill the command FIFO; a strobe into a full FIFO is dropped and flagged.
module jtag_dbg_bridge
  import jtag_dbg_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dbgreg_in,
  input  logic        dbgreg_sel,
  input  logic        dbgreg_strobe,
  output logic [31:0] dbgreg_out,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        dbg_cpu_rst
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  cmd_t             push_data;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_pop;

  state_t           state;
  logic [31:0]      addr;
  logic [31:0]      rd_reg;
  logic             status_view;
  logic             overflow;

  logic [1:0]       head_op;
  logic             ovf_set;
  logic             ovf_clr;
  logic             busy;

  assign push_data = '{sel: dbgreg_sel, word: dbgreg_in};
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign head_op   = head.word[31:30];

  // A drop happens only when full and nothing leaves this cycle
  assign ovf_set = dbgreg_strobe && fifo_full && !fifo_pop;
  assign ovf_clr = fifo_pop && !head.sel && (head_op == OP_CTRL) && head.word[CTRL_CLR_BIT];
  assign busy    = (state == ST_BUS) || !fifo_empty;

  dbg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (dbgreg_strobe),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Read-back mux: captured read data or the live status word
  always_comb begin
    logic [31:0] status;
    status = '0;
    status[STAT_OVF_BIT]                  = overflow;
    status[STAT_BUSY_BIT]                 = busy;
    status[STAT_CNT_LSB+1:STAT_CNT_LSB]   = fifo_count[1:0];
    dbgreg_out = status_view ? status : rd_reg;
  end

  // Sticky overflow; a drop in the same cycle as the clear leaves it set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Command decode and bus-access FSM with registered bus outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      addr        <= '0;
      rd_reg      <= '0;
      status_view <= 1'b0;
      dbg_cpu_rst <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wen     <= 4'h0;
      mem_ren     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            if (head.sel) begin
              mem_addr  <= addr;
              mem_wdata <= head.word;
              mem_wen   <= 4'hF;
              state     <= ST_BUS;
            end else begin
              case (head_op)
                OP_SETADDR: addr <= {head.word[29:0], 2'b00};
                OP_READ: begin
                  mem_addr <= addr;
                  mem_ren  <= 1'b1;
                  state    <= ST_BUS;
                end
                OP_CTRL: begin
                  dbg_cpu_rst <= head.word[CTRL_RST_BIT];
                  status_view <= head.word[CTRL_VIEW_BIT];
                end
                default: ;
              endcase
            end
          end
        end
        ST_BUS: begin
          // Request held stable until the slave signals completion
          if (mem_ready) begin
            if (mem_ren) rd_reg <= mem_rdata;
            addr    <= next_addr(addr);
            mem_ren <= 1'b0;
            mem_wen <= 4'h0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_dbg_bridge.sv
// Scoreboard bench for jtag_dbg_bridge: issued words update a reference model
// and queue expected bus accesses; a bus-slave monitor checks each access.
module tb_jtag_dbg_bridge;

  logic        clk;
  logic        rstn;
  logic [31:0] dbgreg_in;
  logic        dbgreg_sel;
  logic        dbgreg_strobe;
  logic [31:0] dbgreg_out;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wen;
  logic        mem_ren;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        dbg_cpu_rst;

  jtag_dbg_bridge #(.FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .dbgreg_in     (dbgreg_in),
    .dbgreg_sel    (dbgreg_sel),
    .dbgreg_strobe (dbgreg_strobe),
    .dbgreg_out    (dbgreg_out),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wen       (mem_wen),
    .mem_ren       (mem_ren),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .dbg_cpu_rst   (dbg_cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%08h required=%08h @%0t", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          view0;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] m_addr, m_rd;
  bit          m_view, m_rst, m_ovf;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  task automatic model_reset();
    m_addr = 0; m_rd = 0; m_view = 0; m_rst = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_out();
    return m_view ? {m_ovf, 31'b0} : m_rd;
  endfunction

  // Aligns the caller to just after a rising edge
  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Drives one strobe; ends aligned so consecutive calls are back-to-back
  task automatic send(input bit sel, input logic [31:0] w);
    dbgreg_sel = sel; dbgreg_in = w; dbgreg_strobe = 1'b1;
    @(posedge clk); #1;
    dbgreg_strobe = 1'b0;
  endtask

  task automatic issue(input bit sel, input logic [31:0] w);
    exp_t e;
    logic [31:0] rv;
    if (sel) begin
      e.wr = 1; e.addr = m_addr; e.data = w; e.view0 = !m_view;
      exp_q.push_back(e);
      model_mem[m_addr] = w;
      m_addr = m_addr + 4;
    end else begin
      case (w[31:30])
        2'b00: m_addr = {w[29:0], 2'b00};
        2'b01: begin
          rv = model_mem.exists(m_addr) ? model_mem[m_addr] : init_val(m_addr);
          e.wr = 0; e.addr = m_addr; e.data = rv; e.view0 = !m_view;
          exp_q.push_back(e);
          m_rd = rv;
          m_addr = m_addr + 4;
        end
        2'b10: begin
          m_rst = w[0]; m_view = w[1];
          if (w[2]) m_ovf = 0;
        end
        default: ;
      endcase
    end
    send(sel, w);
  endtask

  task automatic wait_idle(input string name);
    int  idle;
    bit  done;
    idle = 0; done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mem_ren && mem_wen == 4'h0 && !mem_ready) idle++;
      else idle = 0;
      if (idle >= 4) begin done = 1; break; end
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout actual=pending%0d required=pending0", name, exp_q.size());
    end
  endtask

  // ---------------- bus slave + scoreboard monitor ----------------
  bit          hold_ready;
  int          force_dly;
  int          cnt, dly;
  bit          pend_chk, pend_v0;
  logic [31:0] pend_data;

  initial begin
    exp_t e;
    mem_ready = 0; mem_rdata = 0; cnt = -1; pend_chk = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mem_ready = 0; cnt = -1; pend_chk = 0;
      end else begin
        if (pend_chk) begin
          check("req_low_after_ready", {27'b0, mem_ren, mem_wen}, 32'h0);
          if (pend_v0) check("read_data_out", dbgreg_out, pend_data);
          pend_chk = 0;
        end
        if (mem_ready) begin
          mem_ready = 0;
          mem_rdata = $urandom;
        end else if (mem_ren || mem_wen != 4'h0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_req", {27'b0, mem_ren, mem_wen}, 32'h0);
            mem_ready = 1;
          end else begin
            e = exp_q[0];
            check("req_kind", {27'b0, mem_ren, mem_wen}, e.wr ? 32'h0F : 32'h10);
            check("req_addr", mem_addr, e.addr);
            if (e.wr) check("req_wdata", mem_wdata, e.data);
            if (cnt < 0) begin
              cnt = 0;
              dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 4));
            end
            if (!hold_ready) begin
              if (cnt >= dly) begin
                exp_q.delete(0);
                if (e.wr) slave_mem[mem_addr] = mem_wdata;
                else mem_rdata = slave_mem.exists(mem_addr) ? slave_mem[mem_addr] : init_val(mem_addr);
                mem_ready = 1;
                pend_chk  = 1;
                pend_v0   = !e.wr && e.view0;
                pend_data = e.data;
                cnt       = -1;
              end else begin
                cnt++;
              end
            end
          end
        end
      end
    end
  end

  // Hang guard
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w, a;
    rstn = 0; dbgreg_in = 0; dbgreg_sel = 0; dbgreg_strobe = 0;
    hold_ready = 0; force_dly = -1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dbgreg_out", dbgreg_out, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_req", {27'b0, mem_ren, mem_wen}, 32'h0);
    check("rst_cpu_rst", {31'b0, dbg_cpu_rst}, 32'h0);
    rstn = 1;

    // Write at 0x400 with a 3-cycle stall, then read it back at the same address
    force_dly = 3;
    sync();
    issue(0, 32'h0000_0100);
    issue(1, 32'hDEAD_BEEF);
    wait_idle("write400");
    force_dly = -1;
    sync();
    issue(1, 32'h1234_5678);
    issue(0, 32'h0000_0100);
    issue(0, 32'h4000_0000);
    wait_idle("readback400");
    check("readback_400", dbgreg_out, 32'hDEAD_BEEF);

    // Two reads at 0x40 / 0x44 with known slave contents
    model_mem[32'h40] = 32'h1111_1111; slave_mem[32'h40] = 32'h1111_1111;
    model_mem[32'h44] = 32'h2222_2222; slave_mem[32'h44] = 32'h2222_2222;
    sync();
    issue(0, 32'h0000_0010);
    issue(0, 32'h4000_0000);
    issue(0, 32'h4000_0000);
    wait_idle("read2");
    check("read2_final", dbgreg_out, 32'h2222_2222);

    // Address wrap at the top of the space
    sync();
    issue(0, 32'h3FFF_FFFF);
    issue(1, 32'hA5A5_0001);
    issue(1, 32'hA5A5_0002);
    wait_idle("wrap");

    // Overflow: stalled bus, status view on, four back-to-back data words
    sync();
    issue(0, 32'h8000_0002);
    wait_idle("view_on");
    check("status_idle", dbgreg_out, 32'h0);
    hold_ready = 1;
    sync();
    issue(1, 32'h0000_00A1);
    issue(1, 32'h0000_00A2);
    issue(1, 32'h0000_00A3);
    m_ovf = 1;
    send(1, 32'h0000_00A4);
    @(negedge clk);
    check("status_full_ovf", dbgreg_out, 32'hE000_0000);
    hold_ready = 0;
    wait_idle("drain");
    check("status_ovf_idle", dbgreg_out, model_out());
    sync();
    issue(0, 32'h8000_0006);
    wait_idle("ovf_clear");
    check("status_cleared", dbgreg_out, model_out());
    sync();
    issue(0, 32'h8000_0000);
    wait_idle("view_off");
    check("view_off_rd", dbgreg_out, model_out());

    // CPU reset latency, read request latency, then async reset mid-read
    sync();
    issue(0, 32'h8000_0001);
    @(negedge clk);
    check("cpu_rst_t1", {31'b0, dbg_cpu_rst}, 32'h0);
    @(negedge clk);
    check("cpu_rst_t2", {31'b0, dbg_cpu_rst}, {31'b0, m_rst});
    hold_ready = 1;
    a = m_addr;
    sync();
    issue(0, 32'h4000_0000);
    @(negedge clk);
    check("ren_t1", {31'b0, mem_ren}, 32'h0);
    @(negedge clk);
    check("ren_t2", {31'b0, mem_ren}, 32'h1);
    check("ren_t2_addr", mem_addr, a);
    #2 rstn = 0;
    #1;
    check("arst_ren", {27'b0, mem_ren, mem_wen}, 32'h0);
    check("arst_cpu_rst", {31'b0, dbg_cpu_rst}, 32'h0);
    check("arst_dbgreg_out", dbgreg_out, 32'h0);
    model_reset();
    hold_ready = 0;
    @(negedge clk);
    rstn = 1;

    // Randomized traffic against the model
    for (int n = 0; n < 200; n++) begin
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    w = {2'b00, 22'b0, 8'($urandom_range(0, 255))};
        2, 3, 4: w = {2'b01, 30'($urandom)};
        5:       w = {2'b10, 27'b0, 3'($urandom_range(0, 7))};
        6:       w = {2'b11, 30'($urandom)};
        default: w = $urandom;
      endcase
      for (int g = 0; g < 100 && exp_q.size() != 0; g++) @(negedge clk);
      sync();
      issue(k >= 7, w);
      if (n % 25 == 24) begin
        wait_idle("rand_idle");
        check("rand_dbgreg_out", dbgreg_out, model_out());
        check("rand_cpu_rst", {31'b0, dbg_cpu_rst}, {31'b0, m_rst});
      end
    end
    wait_idle("final");
    check("final_dbgreg_out", dbgreg_out, model_out());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
